// File: rtl/arcade_input_pkg.sv
// Shared definitions for the arcade input mapper: joystick word width,
// coin FSM state encoding and counter sizing helper.
package arcade_input_pkg;

    localparam int JOY_W            = 16;
    localparam int DEFAULT_COIN_BIT = 9;
    localparam int DEFAULT_FIRE_BIT = 4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PULSE   = 2'd1,
        ST_HOLDOFF = 2'd2
    } coin_state_e;

    // Bits needed to hold 0..max_value-1, never narrower than one bit.
    function automatic int cnt_width(input int max_value);
        return (max_value > 1) ? $clog2(max_value) : 1;
    endfunction

endpackage

// File: rtl/arcade_input_mapper_coin_pulser.sv
// One coin lane: turns a rising coin switch into a fixed-width active-low
// pulse followed by a hold-off window in which new rises are dropped.
module coin_pulser
    import arcade_input_pkg::*;
#(
    parameter int COIN_CYCLES    = 25000,
    parameter int HOLDOFF_CYCLES = 25000
) (
    input  logic clk_sys,
    input  logic reset,
    input  logic i_coin,
    output logic o_start,
    output logic o_coin_n
);

    localparam int MAX_CYC = (COIN_CYCLES > HOLDOFF_CYCLES) ? COIN_CYCLES : HOLDOFF_CYCLES;
    localparam int CW      = cnt_width(MAX_CYC);

    coin_state_e     r_state;
    logic [CW-1:0]   r_cnt;
    logic            r_prev;
    logic            r_coin_n;
    logic            w_rise;
    logic            w_cnt_zero;

    assign w_rise     = i_coin & ~r_prev;
    assign w_cnt_zero = (r_cnt == {CW{1'b0}});
    assign o_coin_n   = r_coin_n;

    // Accept decision; the last hold-off cycle may accept directly so the
    // minimum high time between pulses is exactly HOLDOFF_CYCLES.
    always_comb begin
        o_start = 1'b0;
        case (r_state)
            ST_IDLE:    o_start = w_rise;
            ST_HOLDOFF: o_start = w_rise & w_cnt_zero;
            default:    o_start = 1'b0;
        endcase
    end

    // Coin FSM, down-counter, switch history and registered pulse output.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_cnt    <= {CW{1'b0}};
            r_prev   <= 1'b1;
            r_coin_n <= 1'b1;
        end else begin
            r_prev <= i_coin;
            if (o_start) begin
                r_state  <= ST_PULSE;
                r_cnt    <= CW'(COIN_CYCLES - 1);
                r_coin_n <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        r_coin_n <= 1'b1;
                    end
                    ST_PULSE: begin
                        if (w_cnt_zero) begin
                            r_state  <= ST_HOLDOFF;
                            r_cnt    <= CW'(HOLDOFF_CYCLES - 1);
                            r_coin_n <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt - CW'(1);
                        end
                    end
                    ST_HOLDOFF: begin
                        if (w_cnt_zero) begin
                            r_state <= ST_IDLE;
                        end else begin
                            r_cnt <= r_cnt - CW'(1);
                        end
                    end
                    default: begin
                        r_state  <= ST_IDLE;
                        r_cnt    <= {CW{1'b0}};
                        r_coin_n <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule

// File: rtl/arcade_input_mapper.sv
// Joystick-to-arcade input conditioner: registered active-low buttons with
// optional autofire/merging, per-player coin pulsers and a credit counter.
module arcade_input_mapper
    import arcade_input_pkg::*;
#(
    parameter int NUM_PLAYERS    = 2,
    parameter int NUM_BUTTONS    = 8,
    parameter int COIN_BIT       = DEFAULT_COIN_BIT,
    parameter int FIRE_BIT       = DEFAULT_FIRE_BIT,
    parameter int COIN_CYCLES    = 25000,
    parameter int HOLDOFF_CYCLES = 25000,
    parameter int AUTOFIRE_DIV   = 1250000,
    parameter int MERGE          = 0
) (
    input  logic                               clk_sys,
    input  logic                               reset,
    input  logic [NUM_PLAYERS*JOY_W-1:0]       joy,
    input  logic [NUM_PLAYERS-1:0]             autofire_en,
    output logic [NUM_PLAYERS*NUM_BUTTONS-1:0] btn_n,
    output logic [NUM_PLAYERS-1:0]             coin_n,
    output logic [7:0]                         coin_count
);

    localparam int AFW = cnt_width(AUTOFIRE_DIV);
    localparam int NBT = NUM_PLAYERS * NUM_BUTTONS;

    logic [AFW-1:0]         r_af_cnt;
    logic                   r_af_phase;
    logic [NBT-1:0]         r_btn_n;
    logic [7:0]             r_count;
    logic [NUM_BUTTONS-1:0] w_joy_or;
    logic [NUM_BUTTONS-1:0] w_src [NUM_PLAYERS];
    logic [NUM_PLAYERS-1:0] w_af_on;
    logic [NBT-1:0]         w_btn_next;
    logic [NUM_PLAYERS-1:0] w_start;
    logic [7:0]             w_add;
    logic                   w_unused_joy;

    // Only the button and coin bits matter; the rest of each word is ignored.
    assign w_unused_joy = ^joy;

    // OR of every player's button bits, used when lanes are merged.
    always_comb begin
        w_joy_or = {NUM_BUTTONS{1'b0}};
        for (int p = 0; p < NUM_PLAYERS; p++) begin
            w_joy_or = w_joy_or | joy[p*JOY_W +: NUM_BUTTONS];
        end
    end

    // Per-lane button source and autofire enable selection.
    always_comb begin
        for (int p = 0; p < NUM_PLAYERS; p++) begin
            if (MERGE != 0) begin
                w_src[p]   = w_joy_or;
                w_af_on[p] = |autofire_en;
            end else begin
                w_src[p]   = joy[p*JOY_W +: NUM_BUTTONS];
                w_af_on[p] = autofire_en[p];
            end
        end
    end

    // Invert to active-low; a held fire bit under autofire follows the phase.
    always_comb begin
        w_btn_next = {NBT{1'b1}};
        for (int p = 0; p < NUM_PLAYERS; p++) begin
            w_btn_next[p*NUM_BUTTONS +: NUM_BUTTONS] = ~w_src[p];
            if (w_af_on[p] && w_src[p][FIRE_BIT]) begin
                w_btn_next[p*NUM_BUTTONS + FIRE_BIT] = ~r_af_phase;
            end else begin
                w_btn_next[p*NUM_BUTTONS + FIRE_BIT] = ~w_src[p][FIRE_BIT];
            end
        end
    end

    // Shared autofire divider; phase flips each time the divider wraps.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_af_cnt   <= {AFW{1'b0}};
            r_af_phase <= 1'b1;
        end else if (r_af_cnt == AFW'(AUTOFIRE_DIV - 1)) begin
            r_af_cnt   <= {AFW{1'b0}};
            r_af_phase <= ~r_af_phase;
        end else begin
            r_af_cnt   <= r_af_cnt + AFW'(1);
        end
    end

    // Registered button outputs.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_btn_n <= {NBT{1'b1}};
        end else begin
            r_btn_n <= w_btn_next;
        end
    end

    for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_lane
        coin_pulser #(
            .COIN_CYCLES    (COIN_CYCLES),
            .HOLDOFF_CYCLES (HOLDOFF_CYCLES)
        ) u_pulser (
            .clk_sys  (clk_sys),
            .reset    (reset),
            .i_coin   (joy[p*JOY_W + COIN_BIT]),
            .o_start  (w_start[p]),
            .o_coin_n (coin_n[p])
        );
    end

    // Number of lanes whose pulse starts on this edge.
    always_comb begin
        w_add = 8'd0;
        for (int p = 0; p < NUM_PLAYERS; p++) begin
            w_add = w_add + {7'd0, w_start[p]};
        end
    end

    // Credit counter, wraps naturally at 8 bits.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_count <= 8'd0;
        end else begin
            r_count <= r_count + w_add;
        end
    end

    assign btn_n      = r_btn_n;
    assign coin_count = r_count;

endmodule

// File: tb/tb_arcade_input_mapper.sv
// Scoreboard bench: a behavioural model predicts every cycle's outputs for a
// separate-lane and a merged-lane instance; directed checks cover key points.
module tb_arcade_input_mapper;

    localparam int CC = 4;
    localparam int HC = 3;
    localparam int AD = 5;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] joy;
    logic [1:0]  af;
    logic [15:0] btn0, btn1;
    logic [1:0]  coin0, coin1;
    logic [7:0]  cnt0, cnt1;

    always #5 clk = ~clk;

    arcade_input_mapper #(
        .NUM_PLAYERS(2), .NUM_BUTTONS(8), .COIN_BIT(9), .FIRE_BIT(4),
        .COIN_CYCLES(CC), .HOLDOFF_CYCLES(HC), .AUTOFIRE_DIV(AD), .MERGE(0)
    ) dut_sep (
        .clk_sys(clk), .reset(rst), .joy(joy), .autofire_en(af),
        .btn_n(btn0), .coin_n(coin0), .coin_count(cnt0)
    );

    arcade_input_mapper #(
        .NUM_PLAYERS(2), .NUM_BUTTONS(8), .COIN_BIT(9), .FIRE_BIT(4),
        .COIN_CYCLES(CC), .HOLDOFF_CYCLES(HC), .AUTOFIRE_DIV(AD), .MERGE(1)
    ) dut_mrg (
        .clk_sys(clk), .reset(rst), .joy(joy), .autofire_en(af),
        .btn_n(btn1), .coin_n(coin1), .coin_count(cnt1)
    );

    typedef struct packed {
        logic [15:0] b0;
        logic [15:0] b1;
        logic [1:0]  c;
        logic [7:0]  n;
    } exp_t;

    exp_t sbq[$];

    int         low_left [2];
    int         hold_left[2];
    logic       prev_sw  [2];
    int         af_edges;
    logic [7:0] m_cnt;

    int errors = 0;
    int checks = 0;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] model_btn(input bit merge, input logic [31:0] j,
                                              input logic [1:0] en, input bit ph);
        logic [15:0] r;
        logic [15:0] w;
        bit          a;
        r = 16'hFFFF;
        for (int p = 0; p < 2; p++) begin
            w = merge ? (j[15:0] | j[31:16]) : j[p*16 +: 16];
            a = merge ? (en != 2'b00) : en[p];
            r[p*8 +: 8] = ~w[7:0];
            if (a && w[4]) r[p*8 + 4] = ~ph;
        end
        return r;
    endfunction

    // Predict the outputs after the coming edge, push, clock, pop and compare.
    task automatic step();
        exp_t e;
        bit   ph;
        bit   sw;
        bit   rise;
        if (rst) begin
            e.b0 = 16'hFFFF;
            e.b1 = 16'hFFFF;
            e.c  = 2'b11;
            m_cnt = 8'd0;
            af_edges = 0;
            for (int p = 0; p < 2; p++) begin
                low_left[p] = 0; hold_left[p] = 0; prev_sw[p] = 1'b1;
            end
        end else begin
            ph = (((af_edges / AD) % 2) == 0);
            e.b0 = model_btn(1'b0, joy, af, ph);
            e.b1 = model_btn(1'b1, joy, af, ph);
            af_edges++;
            for (int p = 0; p < 2; p++) begin
                sw   = joy[p*16 + 9];
                rise = sw & ~prev_sw[p];
                prev_sw[p] = sw;
                if (low_left[p] == 0 && hold_left[p] <= 1 && rise) begin
                    low_left[p] = CC; hold_left[p] = 0; m_cnt = m_cnt + 8'd1;
                end else if (low_left[p] > 0) begin
                    low_left[p]--;
                    if (low_left[p] == 0) hold_left[p] = HC;
                end else if (hold_left[p] > 0) begin
                    hold_left[p]--;
                end
                e.c[p] = (low_left[p] > 0) ? 1'b0 : 1'b1;
            end
        end
        e.n = m_cnt;
        sbq.push_back(e);
        @(posedge clk);
        #1;
        e = sbq.pop_front();
        check_val("btn_sep",   {16'd0, btn0}, {16'd0, e.b0});
        check_val("btn_mrg",   {16'd0, btn1}, {16'd0, e.b1});
        check_val("coin_sep",  {30'd0, coin0}, {30'd0, e.c});
        check_val("coin_mrg",  {30'd0, coin1}, {30'd0, e.c});
        check_val("count_sep", {24'd0, cnt0}, {24'd0, e.n});
        check_val("count_mrg", {24'd0, cnt1}, {24'd0, e.n});
    endtask

    task automatic idle(input int n);
        joy = 32'd0;
        repeat (n) step();
    endtask

    initial begin
        rst = 1'b1; joy = 32'd0; af = 2'b00;
        #2;
        repeat (3) step();
        check_val("rst_btn", {16'd0, btn0}, 32'h0000FFFF);
        check_val("rst_coin", {30'd0, coin0}, 32'd3);
        check_val("rst_count", {24'd0, cnt0}, 32'd0);
        rst = 1'b0;
        idle(2);

        joy[4] = 1'b1; step();
        check_val("p1_fire", {16'd0, btn0}, 32'h0000FFEF);
        check_val("p1_fire_merge", {16'd0, btn1}, 32'h0000EFEF);
        idle(1);

        // Single coin, then a retry two cycles into hold-off (dropped).
        joy[9] = 1'b1; step();
        check_val("coin_fall", {30'd0, coin0}, 32'd2);
        check_val("coin_cnt1", {24'd0, cnt0}, 32'd1);
        idle(5);
        joy[9] = 1'b1; step();
        check_val("early_retry", {30'd0, coin0}, 32'd3);
        idle(8);
        check_val("cnt_after_drop", {24'd0, cnt0}, 32'd1);

        // Retry exactly HOLDOFF cycles after release is accepted.
        joy[9] = 1'b1; step();
        idle(6);
        joy[9] = 1'b1; step();
        check_val("holdoff_edge", {30'd0, coin0}, 32'd2);
        check_val("cnt_after_edge", {24'd0, cnt0}, 32'd3);
        idle(8);

        // Held switch gives one credit; held through reset gives none.
        joy[9] = 1'b1;
        repeat (100) step();
        check_val("held_once", {24'd0, cnt0}, 32'd4);
        rst = 1'b1; repeat (2) step();
        rst = 1'b0; repeat (10) step();
        check_val("held_rst_coin", {30'd0, coin0}, 32'd3);
        check_val("held_rst_cnt", {24'd0, cnt0}, 32'd0);
        idle(1);

        // Reset in the middle of a pulse.
        joy[9] = 1'b1; step();
        joy = 32'd0; step();
        rst = 1'b1; step();
        check_val("midpulse_coin", {30'd0, coin0}, 32'd3);
        check_val("midpulse_cnt", {24'd0, cnt0}, 32'd0);
        rst = 1'b0; idle(1);

        // Simultaneous coins on both lanes, 128 times -> wraps to 0.
        for (int k = 0; k < 128; k++) begin
            joy = 32'd0; joy[9] = 1'b1; joy[25] = 1'b1; step();
            if (k == 0) begin
                check_val("dual_coin", {30'd0, coin0}, 32'd0);
                check_val("dual_cnt", {24'd0, cnt0}, 32'd2);
            end
            idle(7);
        end
        check_val("wrap_sep", {24'd0, cnt0}, 32'd0);
        check_val("wrap_mrg", {24'd0, cnt1}, 32'd0);

        // Autofire from a fresh divider.
        rst = 1'b1; step();
        rst = 1'b0; af = 2'b01; joy = 32'd0; joy[4] = 1'b1;
        step();
        check_val("af_start_low", {31'd0, btn0[4]}, 32'd0);
        repeat (4) step();
        check_val("af_still_low", {31'd0, btn0[4]}, 32'd0);
        step();
        check_val("af_goes_high", {31'd0, btn0[4]}, 32'd1);
        repeat (24) step();
        af = 2'b00; repeat (6) step();
        check_val("af_off_steady", {31'd0, btn0[4]}, 32'd0);
        af = 2'b01; repeat (7) step();
        joy = 32'd0; step();
        check_val("af_release", {31'd0, btn0[4]}, 32'd1);
        af = 2'b00;

        // Merge: P2 button 0 drives both merged lanes; P2 coin stays on lane 1.
        joy = 32'h0001_0000; step();
        check_val("merge_btn", {16'd0, btn1}, 32'h0000FEFE);
        check_val("sep_btn", {16'd0, btn0}, 32'h0000FEFF);
        idle(1);
        joy[25] = 1'b1; step();
        check_val("merge_coin", {30'd0, coin1}, 32'd1);
        idle(8);

        // Random traffic with occasional resets.
        repeat (300) begin
            joy = $urandom;
            af  = 2'($urandom_range(0, 3));
            rst = ($urandom_range(0, 63) == 0);
            step();
        end
        rst = 1'b0;
        idle(4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
